// File: rtl/mintz80_tonegen_if.sv
// Z80 side of the tone generator: the select, strobes and address for the $d4-$d7 window.
// The data bus stays a plain inout on the block so the tristate stays at the module boundary.
interface mintz80_tonegen_if;
    logic       extio;
    logic       rd;
    logic       wr;
    logic [1:0] a;

    modport master (output extio, output rd, output wr, output a);
    modport slave  (input  extio, input  rd, input  wr, input  a);
endinterface

// File: rtl/mintz80_tonegen.sv
// Square-wave tone/timer peripheral: 16-bit half-period divider, 8-bit prescaled duration,
// one-shot or continuous, sticky done flag with interrupt. Z80 writes are resynchronised to clk.
//
//  state  | meaning
//  S_IDLE | tone held low, counters frozen, waiting for a CTRL write with en=1
//  S_RUN  | tone divider and duration prescaler counting; busy=1
module mintz80_tonegen #(
    parameter int PRESCALE = 4000,
    parameter int PSW      = 12
) (
    input  logic                clk,
    input  logic                reset,
    mintz80_tonegen_if.slave    bus,
    inout  wire  [7:0]          data,
    output logic                tone,
    output logic                busy,
    output logic                irq_n
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    logic           wr_s1_q, wr_s2_q;
    logic           sel_s1_q, sel_s2_q, sel_s3_q;
    logic [1:0]     cap_a_q;
    logic [7:0]     cap_d_q;
    logic [15:0]    div_q;
    logic [7:0]     dur_q;
    logic           en_q, en_d;
    logic           cont_q, cont_d;
    logic           ie_q, ie_d;
    logic           done_q, done_d;
    state_t         state_q, state_d;
    logic           tone_q, tone_d;
    logic [15:0]    tcnt_q, tcnt_d;
    logic [PSW-1:0] pscnt_q, pscnt_d;
    logic [7:0]     dcnt_q, dcnt_d;
    logic [7:0]     rdata;

    wire capture = !wr_s2_q && !sel_s2_q;
    wire commit  = sel_s2_q && !sel_s3_q;
    wire ctrl_wr = commit && (cap_a_q == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_s1_q  <= 1'b1;
            wr_s2_q  <= 1'b1;
            sel_s1_q <= 1'b1;
            sel_s2_q <= 1'b1;
            sel_s3_q <= 1'b1;
            cap_a_q  <= 2'd0;
            cap_d_q  <= 8'd0;
            div_q    <= 16'd0;
            dur_q    <= 8'd0;
            en_q     <= 1'b0;
            cont_q   <= 1'b0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            state_q  <= S_IDLE;
            tone_q   <= 1'b0;
            tcnt_q   <= 16'd0;
            pscnt_q  <= '0;
            dcnt_q   <= 8'd0;
        end else begin
            wr_s1_q  <= bus.wr;
            wr_s2_q  <= wr_s1_q;
            sel_s1_q <= bus.extio | bus.wr;
            sel_s2_q <= sel_s1_q;
            sel_s3_q <= sel_s2_q;
            // Keep sampling until the synced strobe drops, so the commit uses the last bus value.
            if (capture) begin
                cap_a_q <= bus.a;
                cap_d_q <= data;
            end
            if (commit) begin
                case (cap_a_q)
                    2'd0:    div_q[7:0]  <= cap_d_q;
                    2'd1:    div_q[15:8] <= cap_d_q;
                    2'd2:    dur_q       <= cap_d_q;
                    default: ;
                endcase
            end
            en_q    <= en_d;
            cont_q  <= cont_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            state_q <= state_d;
            tone_q  <= tone_d;
            tcnt_q  <= tcnt_d;
            pscnt_q <= pscnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        tcnt_d  = tcnt_q;
        pscnt_d = pscnt_q;
        dcnt_d  = dcnt_q;
        en_d    = en_q;
        cont_d  = cont_q;
        ie_d    = ie_q;
        done_d  = done_q;

        if (state_q == S_RUN) begin
            // tcnt==0 only happens when started with DIV=0: park the tone low.
            if (tcnt_q == 16'd0) begin
                tone_d = 1'b0;
            end else if (tcnt_q == 16'd1) begin
                tone_d = (div_q != 16'd0) ? ~tone_q : 1'b0;
                tcnt_d = div_q;
            end else begin
                tcnt_d = tcnt_q - 16'd1;
            end

            if (pscnt_q == PS_LAST) begin
                pscnt_d = '0;
                if (!cont_q && dcnt_q != 8'd0) dcnt_d = dcnt_q - 8'd1;
            end else begin
                pscnt_d = pscnt_q + 1'b1;
            end

            if (!cont_q && dcnt_q == 8'd0) begin
                state_d = S_IDLE;
                tone_d  = 1'b0;
                done_d  = 1'b1;
                en_d    = 1'b0;
            end
        end

        // A CTRL write overrides expiry on the same edge.
        if (ctrl_wr) begin
            en_d   = cap_d_q[0];
            cont_d = cap_d_q[1];
            ie_d   = cap_d_q[2];
            done_d = 1'b0;
            tone_d = 1'b0;
            if (cap_d_q[0]) begin
                state_d = S_RUN;
                tcnt_d  = div_q;
                pscnt_d = '0;
                dcnt_d  = dur_q;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        rdata = 8'd0;
        case (bus.a)
            2'd0:    rdata = div_q[7:0];
            2'd1:    rdata = div_q[15:8];
            2'd2:    rdata = dur_q;
            default: rdata = {busy, done_q, 3'b000, ie_q, cont_q, en_q};
        endcase
    end

    assign data  = (!bus.rd && !bus.extio) ? rdata : 8'bz;
    assign tone  = tone_q;
    assign busy  = (state_q == S_RUN);
    assign irq_n = ~(done_q & ie_q);

endmodule

// File: tb/tb_mintz80_tonegen.sv
// Directed bench for mintz80_tonegen with PRESCALE=4: bus writes through the synchroniser,
// combinational reads, tone timing, one-shot duration, stop/restart and reset.
module tb_mintz80_tonegen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mintz80_tonegen_if bus ();
    wire  [7:0] data;
    logic [7:0] drv_d  = 8'd0;
    logic       drv_oe = 1'b0;
    logic       tone, busy, irq_n;

    assign data = drv_oe ? drv_d : 8'bz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup pu (data[i]);
    end

    mintz80_tonegen #(.PRESCALE(4), .PSW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .data  (data),
        .tone  (tone),
        .busy  (busy),
        .irq_n (irq_n)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write ends #1 after the commit edge (third posedge after /WR rises).
    task automatic bus_wr(input logic [1:0] ad, input logic [7:0] d, input logic sel);
        @(negedge clk);
        bus.a     = ad;
        drv_d     = d;
        drv_oe    = 1'b1;
        bus.extio = ~sel;
        bus.wr    = 1'b0;
        repeat (4) @(negedge clk);
        bus.wr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        drv_oe    = 1'b0;
        bus.extio = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] ad, output logic [7:0] v);
        bus.a     = ad;
        bus.extio = 1'b0;
        bus.rd    = 1'b0;
        #2;
        v         = data;
        bus.rd    = 1'b1;
        bus.extio = 1'b1;
        #1;
    endtask

    initial begin
        logic [7:0] v;
        logic       prev;
        int         last, ntog, badint, busylow, cnt, first;
        bit         found;

        bus.extio = 1'b1;
        bus.rd    = 1'b1;
        bus.wr    = 1'b1;
        bus.a     = 2'd0;
        #1;
        chk("rst_tone", tone, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq_n", irq_n, 1);
        bus_rd(2'd3, v); chk("rst_ctrl", v, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Continuous tone, DIV=3
        bus_wr(2'd0, 8'h03, 1'b1);
        bus_wr(2'd1, 8'h00, 1'b1);
        bus_wr(2'd2, 8'h00, 1'b1);
        bus_wr(2'd3, 8'h03, 1'b1);
        chk("tone_start_tone", tone, 0);
        chk("tone_start_busy", busy, 1);
        prev = 1'b0; last = 0; ntog = 0; badint = 0; busylow = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk); #1;
            if (!busy) busylow++;
            if (tone !== prev) begin
                ntog++;
                if (c - last != 3) badint++;
                last = c;
                prev = tone;
            end
        end
        chk("tone_toggles", 16'(ntog), 333);
        chk("tone_bad_intervals", 16'(badint), 0);
        chk("tone_busy_low", 16'(busylow), 0);
        bus_rd(2'd3, v); chk("tone_ctrl_rd", v, 8'h83);
        bus_rd(2'd0, v); chk("tone_divl_rd", v, 8'h03);

        // Decode: deselected write ignored, bus floats unless rd and extio both low
        bus_wr(2'd0, 8'h55, 1'b0);
        bus_rd(2'd0, v); chk("dec_divl_kept", v, 8'h03);
        bus.a = 2'd0; bus.extio = 1'b1; bus.rd = 1'b0; #2;
        chk("dec_z_extio_hi", data, 8'hFF);
        bus.rd = 1'b1; bus.extio = 1'b0; #2;
        chk("dec_z_rd_hi", data, 8'hFF);
        bus.extio = 1'b1; #1;

        // Stop mid-RUN while tone is high
        bus_wr(2'd0, 8'h64, 1'b1);
        bus_wr(2'd3, 8'h03, 1'b1);
        repeat (105) @(posedge clk); #1;
        chk("stop_pre_tone", tone, 1);
        bus_wr(2'd3, 8'h00, 1'b1);
        chk("stop_tone", tone, 0);
        chk("stop_busy", busy, 0);
        bus_rd(2'd3, v); chk("stop_ctrl_rd", v, 8'h00);

        // Restart mid-RUN resets the divider phase
        bus_wr(2'd0, 8'h05, 1'b1);
        bus_wr(2'd2, 8'd200, 1'b1);
        bus_wr(2'd3, 8'h03, 1'b1);
        repeat (7) @(posedge clk); #1;
        bus_wr(2'd3, 8'h01, 1'b1);
        chk("restart_tone", tone, 0);
        chk("restart_busy", busy, 1);
        first = 0; found = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(posedge clk); #1;
            if (tone !== 1'b0) begin
                first = c;
                found = 1'b1;
            end
        end
        chk("restart_first_toggle", 16'(first), 5);
        bus_rd(2'd3, v); chk("restart_ctrl_rd", v, 8'h81);
        bus_wr(2'd3, 8'h00, 1'b1);

        // One-shot DIV=2 DUR=5 with interrupt
        bus_wr(2'd0, 8'h02, 1'b1);
        bus_wr(2'd2, 8'h05, 1'b1);
        bus_wr(2'd3, 8'h05, 1'b1);
        chk("os_busy_start", busy, 1);
        prev = 1'b0; ntog = 0; cnt = 0; found = 1'b0;
        for (int c = 1; c <= 100 && !found; c++) begin
            @(posedge clk); #1;
            if (tone !== prev) begin
                ntog++;
                prev = tone;
            end
            if (!busy) begin
                cnt = c;
                found = 1'b1;
            end
        end
        chk("os_len_in_range", 16'(cnt >= 19 && cnt <= 21), 1);
        chk("os_toggles_in_range", 16'(ntog >= 9 && ntog <= 11), 1);
        chk("os_tone_end", tone, 0);
        repeat (10) @(posedge clk); #1;
        bus_rd(2'd3, v); chk("os_ctrl_rd", v, 8'h44);
        chk("os_irq_n", irq_n, 0);
        bus_rd(2'd2, v); chk("os_dur_rd", v, 8'h05);
        bus_wr(2'd3, 8'h00, 1'b1);
        chk("os_irq_clr", irq_n, 1);
        bus_rd(2'd3, v); chk("os_ctrl_clr", v, 8'h00);

        // One-shot with DUR=0
        bus_wr(2'd2, 8'h00, 1'b1);
        bus_wr(2'd3, 8'h01, 1'b1);
        ntog = 0; cnt = 0; found = 1'b0;
        for (int c = 1; c <= 10 && !found; c++) begin
            @(posedge clk); #1;
            if (tone !== 1'b0) ntog++;
            if (!busy) begin
                cnt = c;
                found = 1'b1;
            end
        end
        chk("dur0_done_fast", 16'(cnt >= 1 && cnt <= 2), 1);
        chk("dur0_no_toggle", 16'(ntog), 0);
        bus_rd(2'd3, v); chk("dur0_ctrl_rd", v, 8'h40);
        chk("dur0_irq_n", irq_n, 1);

        // Reset mid-RUN
        bus_wr(2'd3, 8'h07, 1'b1);
        repeat (5) @(posedge clk); #1;
        chk("mrst_pre_busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst_tone", tone, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_irq_n", irq_n, 1);
        bus_rd(2'd0, v); chk("mrst_divl", v, 8'h00);
        bus_rd(2'd1, v); chk("mrst_divh", v, 8'h00);
        bus_rd(2'd2, v); chk("mrst_dur", v, 8'h00);
        bus_rd(2'd3, v); chk("mrst_ctrl", v, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
